// File: rtl/elevator_pkg.sv
// Shared types and constants for the two-floor elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_e;

    localparam logic       FLOOR_1 = 1'b0;
    localparam logic       FLOOR_2 = 1'b1;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturating BCD digit increment used for the seconds display.
    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] v);
        return (v == BCD_MAX) ? BCD_MAX : v + 4'd1;
    endfunction

endpackage

// File: rtl/elevator_ctrl_tick_gen.sv
// 100 ms tick prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
module tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (presc_q == LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = (presc_q == LAST);

endmodule

// File: rtl/elevator_ctrl.sv
// Two-floor elevator controller with per-phase BCD timer.
// Optional ELEV_DOOR_HOLD_EN adds door_hold, which freezes the dwell timer at 0.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TRAVEL_S    = 3,
    parameter int DOOR_S      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       call_f1,
    input  logic       call_f2,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic       floor_disp,
    output logic       state_up,
    output logic       state_down,
    output logic       state_stay,
    output logic [3:0] cnt_s_disp,
    output logic [3:0] cnt_ms_disp
);
    localparam int         TICK_DIV   = CLK_FREQ_HZ / 10;
    localparam logic [3:0] TRAVEL_BCD = 4'(TRAVEL_S);
    localparam logic [3:0] DOOR_BCD   = 4'(DOOR_S);

    state_e     state_q, state_d;
    logic       floor_q, floor_d;
    logic [1:0] req_q, req_d;
    logic [3:0] cnt_s_q, cnt_s_d;
    logic [3:0] cnt_ms_q, cnt_ms_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       stay_q, stay_d;

    logic       tick_s;
    logic       hold_s;
    logic       clr_s;
    logic       travel_done_s;
    logic       door_done_s;
    logic [1:0] req_clr_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    always_comb begin
        hold_s = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
        if (state_q == DOOR) begin
            hold_s = door_hold;
        end else begin
            hold_s = 1'b0;
        end
`endif
        travel_done_s = (cnt_s_q == TRAVEL_BCD) && (cnt_ms_q == 4'd0) && !tick_s;
        door_done_s   = (cnt_s_q == DOOR_BCD) && (cnt_ms_q == 4'd0) && !tick_s;

        state_d = state_q;
        floor_d = floor_q;
        case (state_q)
            IDLE: begin
                if (req_q[floor_q]) begin
                    state_d = DOOR;
                end else if (req_q[~floor_q]) begin
                    state_d = (floor_q == FLOOR_1) ? MOVE_UP : MOVE_DOWN;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (travel_done_s) begin
                    state_d = DOOR;
                    floor_d = ~floor_q;
                end else begin
                    state_d = state_q;
                end
            end
            DOOR: begin
                if (door_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DOOR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clr_s = (state_d != state_q) || hold_s;

        // Clearing on every DOOR cycle also absorbs calls for the floor being served.
        req_clr_s = 2'b00;
        if (state_d == DOOR) begin
            req_clr_s[floor_d] = 1'b1;
        end else begin
            req_clr_s = 2'b00;
        end
        req_d = (req_q | {call_f2, call_f1}) & ~req_clr_s;

        cnt_s_d  = cnt_s_q;
        cnt_ms_d = cnt_ms_q;
        if (clr_s) begin
            cnt_s_d  = 4'd0;
            cnt_ms_d = 4'd0;
        end else if (tick_s) begin
            if (cnt_ms_q == BCD_MAX) begin
                cnt_ms_d = 4'd0;
                cnt_s_d  = bcd_inc_sat(cnt_s_q);
            end else begin
                cnt_ms_d = cnt_ms_q + 4'd1;
            end
        end else begin
            cnt_s_d  = cnt_s_q;
            cnt_ms_d = cnt_ms_q;
        end

        up_d   = (state_d != MOVE_UP);
        down_d = (state_d != MOVE_DOWN);
        stay_d = !((state_d == IDLE) || (state_d == DOOR));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            floor_q  <= FLOOR_1;
            req_q    <= 2'b00;
            cnt_s_q  <= 4'd0;
            cnt_ms_q <= 4'd0;
            up_q     <= 1'b1;
            down_q   <= 1'b1;
            stay_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            req_q    <= req_d;
            cnt_s_q  <= cnt_s_d;
            cnt_ms_q <= cnt_ms_d;
            up_q     <= up_d;
            down_q   <= down_d;
            stay_q   <= stay_d;
        end
    end

    assign floor_disp  = floor_q;
    assign state_up    = up_q;
    assign state_down  = down_q;
    assign state_stay  = stay_q;
    assign cnt_s_disp  = cnt_s_q;
    assign cnt_ms_disp = cnt_ms_q;

endmodule
